// File: rtl/regfile_multi.sv
// regfile_multi: parametrised multi-read-port register file with a post-reset init sequencer.
// Latency: reads are combinational; writes land on the next rising edge of clk; ready rises NREGS clocks after reset release.
// Backpressure: none; writes while not ready or to read-only entries are dropped and flagged on ro_err.
// Optional macro REGFILE_MULTI_BYPASS_EN: forward accepted RUN writes to matching read ports.
module regfile_multi #(
  parameter int DW    = 8,
  parameter int NREGS = 16,
  parameter int NRD   = 2,
  parameter logic [NREGS*DW-1:0] INIT = 128'h0000_0000_00FD_FBF9_00FF_01FE_FF41_0302,
  parameter logic [NREGS-1:0]    RO_MASK = 16'h00E0,
  localparam int AW = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DW-1:0]     wr_data,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*DW-1:0] rd_data,
  output logic              ready,
  output logic              ro_err
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            ready_q, ready_d;
  logic            ro_err_q, ro_err_d;

  // Storage is not reset; the sequencer overwrites every entry after reset.
  logic [DW-1:0]   mem_q [NREGS];

  // Single shared write port (sequencer in INIT, external port in RUN).
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [DW-1:0]   mem_wdata;

  // Accepted external write in RUN; used for forwarding when enabled.
  logic            wr_ok;

  // Next-state, init sequencing, write-port mux and rejection flag.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ready_d   = ready_q;
    ro_err_d  = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    wr_ok     = 1'b0;

    case (state_q)
      ST_INIT: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = INIT[32'(cnt_q)*DW +: DW];
        cnt_d     = cnt_q + AW'(1);
        if (cnt_q == AW'(NREGS - 1)) begin
          state_d = ST_RUN;
          ready_d = 1'b1;
        end
        // External writes are not accepted until the table is loaded.
        if (we) ro_err_d = 1'b1;
      end
      ST_RUN: begin
        if (we) begin
          if (RO_MASK[wr_addr]) begin
            ro_err_d = 1'b1;
          end else begin
            mem_we = 1'b1;
            wr_ok  = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
        ready_d = 1'b0;
      end
    endcase

    // Reset edge performs no array write so nothing stray lands during reset.
    if (!rst_n) mem_we = 1'b0;
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_INIT;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      ro_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      ro_err_q <= ro_err_d;
    end
  end

  // Array write port.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  // Independent combinational read ports.
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] ra;
    assign ra = rd_addr[k*AW +: AW];
`ifdef REGFILE_MULTI_BYPASS_EN
    assign rd_data[k*DW +: DW] = (wr_ok && (ra == wr_addr)) ? wr_data : mem_q[ra];
`else
    assign rd_data[k*DW +: DW] = mem_q[ra];
`endif
  end

`ifndef REGFILE_MULTI_BYPASS_EN
  // Without forwarding the accepted-write indication has no consumer.
  logic unused_wr_ok;
  assign unused_wr_ok = wr_ok;
`endif

  assign ready  = ready_q;
  assign ro_err = ro_err_q;

endmodule

// File: tb/tb_regfile_multi.sv
// Directed bench for regfile_multi: default 16x8/2-port instance plus a 32x16/3-port instance.
// Checks init latency and contents, RUN writes, read-only rejection, writes during init and reset mid-init.
// All expected values are hand-derived constants or a small formula local to the bench.
module tb_regfile_multi;

  // ---------------- instance A: default parameters ----------------
  logic        clk = 1'b0;
  logic        rst_n_a, we_a, ready_a, ro_err_a;
  logic [3:0]  wr_addr_a;
  logic [7:0]  wr_data_a;
  logic [7:0]  rd_addr_a;
  logic [15:0] rd_data_a;

  regfile_multi dut_a (
    .clk(clk), .rst_n(rst_n_a), .we(we_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
    .rd_addr(rd_addr_a), .rd_data(rd_data_a), .ready(ready_a), .ro_err(ro_err_a)
  );

  // ---------------- instance B: DW=16, NREGS=32, NRD=3, no RO ----------------
  function automatic logic [15:0] b_val(input int i);
    return 16'(16'h0F00 + i * 16'h0123);
  endfunction

  function automatic logic [511:0] make_init_b();
    logic [511:0] v;
    v = '0;
    for (int i = 0; i < 32; i++) v[i*16 +: 16] = b_val(i);
    return v;
  endfunction

  localparam logic [511:0] INIT_B = make_init_b();

  logic        rst_n_b, we_b, ready_b, ro_err_b;
  logic [4:0]  wr_addr_b;
  logic [15:0] wr_data_b;
  logic [14:0] rd_addr_b;
  logic [47:0] rd_data_b;

  regfile_multi #(.DW(16), .NREGS(32), .NRD(3), .INIT(INIT_B), .RO_MASK(32'h0)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .we(we_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
    .rd_addr(rd_addr_b), .rd_data(rd_data_b), .ready(ready_b), .ro_err(ro_err_b)
  );

  always #5 clk = ~clk;

  // Expected default init contents (bytes of the default INIT vector).
  logic [7:0] exp_a [16] = '{8'h02, 8'h03, 8'h41, 8'hFF, 8'hFE, 8'h01, 8'hFF, 8'h00,
                             8'hF9, 8'hFB, 8'hFD, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

  localparam logic [7:0] EXP_SAME =
`ifdef REGFILE_MULTI_BYPASS_EN
    8'h5A;
`else
    8'h41;
`endif

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until instance A's ready rises; returns limit+1 if it never does.
  task automatic wait_ready_a(input int limit, output int n);
    n = 0;
    while (n <= limit) begin
      step();
      n++;
      if (ready_a) return;
    end
  endtask

  task automatic read_a(input logic [3:0] a0, input logic [3:0] a1);
    rd_addr_a = {a1, a0};
    #1;
  endtask

  initial begin
    int n;
    rst_n_a = 1'b0; we_a = 1'b0; wr_addr_a = '0; wr_data_a = '0; rd_addr_a = '0;
    rst_n_b = 1'b0; we_b = 1'b0; wr_addr_b = '0; wr_data_b = '0; rd_addr_b = '0;

    // Reset held for three edges.
    repeat (3) step();
    check("reset_ready", ready_a, 0);
    check("reset_ro_err", ro_err_a, 0);

    // Release and walk through init, injecting a write on the 4th init edge.
    rst_n_a = 1'b1;
    n = 0;
    while (n <= 40) begin
      step();
      n++;
      if (n == 3) begin
        we_a = 1'b1; wr_addr_a = 4'd0; wr_data_a = 8'hAA;
      end
      if (n == 4) begin
        check("init_wr_ro_err", ro_err_a, 1);
        we_a = 1'b0;
      end
      if (n == 5) check("init_wr_ro_err_clr", ro_err_a, 0);
      if (ready_a) break;
    end
    check("init_latency", n, 16);

    // Full table readout on both ports.
    for (int i = 0; i < 16; i++) begin
      read_a(4'(i), 4'(15 - i));
      check("init_p0", rd_data_a[7:0], exp_a[i]);
      check("init_p1", rd_data_a[15:8], exp_a[15 - i]);
    end

    // Accepted write 2 <= 5A, same-cycle read, then next-cycle reads.
    we_a = 1'b1; wr_addr_a = 4'd2; wr_data_a = 8'h5A;
    read_a(4'd2, 4'd7);
    check("same_cycle_e2", rd_data_a[7:0], EXP_SAME);
    step();
    we_a = 1'b0;
    read_a(4'd2, 4'd0);
    check("wr_e2", rd_data_a[7:0], 8'h5A);
    check("rd_e0", rd_data_a[15:8], 8'h02);
    check("wr_ok_no_err", ro_err_a, 0);

    // Rejected write to read-only entry 7; never forwarded.
    we_a = 1'b1; wr_addr_a = 4'd7; wr_data_a = 8'h33;
    read_a(4'd7, 4'd7);
    check("ro7_no_fwd", rd_data_a[7:0], 8'h00);
    step();
    we_a = 1'b0;
    check("ro7_err", ro_err_a, 1);
    step();
    check("ro7_err_clr", ro_err_a, 0);
    read_a(4'd7, 4'd6);
    check("ro7_val", rd_data_a[7:0], 8'h00);
    check("ro6_val", rd_data_a[15:8], 8'hFF);

    // Two back-to-back rejected writes to entry 5.
    we_a = 1'b1; wr_addr_a = 4'd5; wr_data_a = 8'hAA;
    step();
    check("ro5_err1", ro_err_a, 1);
    wr_data_a = 8'hBB;
    step();
    we_a = 1'b0;
    check("ro5_err2", ro_err_a, 1);
    step();
    check("ro5_err_clr", ro_err_a, 0);
    read_a(4'd5, 4'd5);
    check("ro5_val", rd_data_a[7:0], 8'h01);

    // Write 1 <= 77, then reset and abort the sequencer mid-init.
    we_a = 1'b1; wr_addr_a = 4'd1; wr_data_a = 8'h77;
    step();
    we_a = 1'b0;
    read_a(4'd1, 4'd0);
    check("wr_e1", rd_data_a[7:0], 8'h77);
    rst_n_a = 1'b0;
    step();
    check("rst2_ready", ready_a, 0);
    rst_n_a = 1'b1;
    repeat (8) step();
    check("mid_init_ready", ready_a, 0);
    rst_n_a = 1'b0;
    step();
    check("mid_rst_ready", ready_a, 0);
    rst_n_a = 1'b1;
    wait_ready_a(40, n);
    check("reinit_latency", n, 16);
    read_a(4'd1, 4'd10);
    check("reinit_e1", rd_data_a[7:0], 8'h03);
    check("reinit_eA", rd_data_a[15:8], 8'hFD);

    // ---------------- instance B ----------------
    rst_n_b = 1'b1;
    n = 0;
    while (n <= 80) begin
      step();
      n++;
      if (ready_b) break;
    end
    check("b_init_latency", n, 32);
    for (int i = 0; i < 32; i++) begin
      rd_addr_b = {5'((i + 19) % 32), 5'((i + 7) % 32), 5'(i)};
      #1;
      check("b_p0", rd_data_b[15:0],  b_val(i));
      check("b_p1", rd_data_b[31:16], b_val((i + 7) % 32));
      check("b_p2", rd_data_b[47:32], b_val((i + 19) % 32));
    end
    for (int i = 5; i < 8; i++) begin
      we_b = 1'b1; wr_addr_b = 5'(i); wr_data_b = 16'(16'hBE00 + i);
      step();
      we_b = 1'b0;
      check("b_no_ro_err", ro_err_b, 0);
      rd_addr_b = {5'(0), 5'(31), 5'(i)};
      #1;
      check("b_wr", rd_data_b[15:0], 16'(16'hBE00 + i));
      check("b_e31", rd_data_b[31:16], b_val(31));
      check("b_e0", rd_data_b[47:32], b_val(0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_multi.md
Name: regfile_multi

Overview:
- Parametrised successor to the 65C02 core's 16x8 register file.
- Generic width, depth and read-port count, one write port, asynchronous (combinational) reads.
- After reset, a hardware init sequencer loads every entry from a parameter vector, so constant entries (INC, DEC, zero, vectors) come from the sequencer rather than FPGA INIT attributes.
- Parameter-selected entries are write-protected constants; illegal writes are flagged. Sits between microcode decode and the ALU.

Parameters:
- DW, 8, data width in bits.
- NREGS, 16, number of entries; power of two, 2..64.
- NRD, 2, number of independent read ports, 1..4.
- INIT, {16'h0000..} default 128'h0000_0000_0000_0000_0000_FDFB_F900_FF01_FEFF_4103_02 zero-extended, flattened init values; entry i = INIT[i*DW +: DW].
- RO_MASK, 16'h00E0, bit i=1 makes entry i read-only after init (default entries 5,6,7 = INC, DEC, zero).
- Localparam AW = $clog2(NREGS).

Ports:
- clk  in  1  clock, all state changes on rising edge.
- rst_n  in  1  synchronous active-low reset.
- we  in  1  write enable.
- wr_addr  in  AW  write entry.
- wr_data  in  DW  write data.
- rd_addr  in  NRD*AW  read addresses; port k = rd_addr[k*AW +: AW].
- rd_data  out  NRD*DW  read data; port k = rd_data[k*DW +: DW], combinational from rd_addr.
- ready  out  1  1 = init finished, writes accepted.
- ro_err  out  1  registered one-cycle pulse: a write was rejected.

Behaviour:
- Reset and clocking:
  - Only one clock. Reset is synchronous and active-low: sampled on the rising edge of clk when rst_n=0.
  - Reset values: ready=0, ro_err=0, FSM=INIT, init counter=0.
  - Array contents are not cleared by reset; they are overwritten by the sequencer.
- FSM states:
  - INIT: each cycle writes INIT[cnt] to entry cnt (write protection bypassed), then cnt <= cnt+1. Entry NREGS-1 is written on the cycle where cnt==NREGS-1; next state is RUN and ready <= 1.
  - ready therefore rises exactly NREGS clocks after the first edge with rst_n=1.
  - RUN: stays until rst_n=0. rst_n=0 in any state, including mid-INIT, returns to INIT with cnt=0 on that edge.
- External write (RUN only):
  - we=1 and RO_MASK[wr_addr]=0: entry wr_addr <= wr_data at the edge.
  - we=1 and RO_MASK[wr_addr]=1: entry unchanged; ro_err=1 for the following cycle.
  - we=1 during INIT: ignored; ro_err=1 next cycle.
  - ro_err is 0 in all other cycles. A new rejected write on consecutive cycles keeps it high.
- Reads:
  - rd_data[k] = mem[rd_addr[k]], no latency. All ports are independent; any port may alias another.
  - During INIT, reads return current array contents. Entries not yet initialised are undefined and must not be checked.
  - Read of the entry being written returns the old value until the edge (write-after-read), unless the bypass option is enabled.
- Width rules: wr_addr and rd_addr are exactly AW bits, and every code 0..NREGS-1 is valid; there is no out-of-range case.
- Implementation: distributed RAM is expected, so there is one write address shared by the sequencer and the external port. The write mux selects the sequencer when FSM=INIT.

Optional Feature:
- Macro: REGFILE_MULTI_BYPASS_EN.
- Defined: when we=1 in RUN, RO_MASK[wr_addr]=0 and rd_addr[k]==wr_addr, rd_data[k]=wr_data combinationally in the same cycle (write-through forwarding). Rejected writes and INIT writes are never forwarded.
- Undefined: there is no forwarding; reads show the old value until the clock edge.
- Array timing is identical in both builds.

Test Plan:
- Init: hold rst_n=0 3 cycles, release, read all 16 entries after ready -> ready rises exactly 16 clocks after release; entry0=02, 1=03, 2=41, 3=FF, 5=01, 6=FF, 7=00, 8=F9, 9=FB, A=FD.
- Write/read in RUN: write 2<=5A, then next cycle port0 reads 2 and port1 reads 0 -> 5A and 02. Same-cycle read of entry 2 -> 41 without the bypass, 5A with REGFILE_MULTI_BYPASS_EN.
- Read-only: write 7<=33 in RUN -> ro_err=1 exactly one cycle; entry 7 still 00. Two back-to-back writes to 5 -> ro_err high 2 cycles; entry 5 still 01.
- Write during INIT: we=1, wr_addr=0, wr_data=AA at cycle 4 of init -> ro_err pulse; after ready entry0=02.
- Reset mid-init: assert rst_n=0 at cycle 8 of init after writing 1<=77 earlier in RUN -> ready stays 0; ready rises 16 clocks after the new release; entry1=03.
- Parametrisation: DW=16, NREGS=32, NRD=3, RO_MASK=0 -> all 32 entries equal INIT slices; three ports read distinct entries simultaneously; no ro_err on any write.
